// File: rtl/io_output_bank.sv
// io_output_bank: bank of NPORTS memory-mapped output registers on the CPU
// I/O bus. Each port supports byte-strobed writes, atomic SET/CLR/TOGGLE
// aliases and registered readback. It also has an optional auto-clear pulse
// timer, so software can fire one-shot strobes without polling.
//
// Address map, relative to BASE_ADDR. One region is NPORTS words wide:
//   region r, port p -> byte offset (r * NPORTS + p) * 4
//   r = 0 DATA, 1 SET, 2 CLR, 3 TOG, 4 PLEN, 5 CNT (read-only), 6/7 reserved
module io_output_bank #(
  parameter int          NPORTS    = 4,
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080
) (
  input  logic                     io_clk,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [31:0]              datain,
  input  logic [3:0]               wstrb,
  input  logic                     write_io_enable,
  input  logic                     read_io_enable,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [NPORTS*DATA_W-1:0] out_ports,
  output logic [NPORTS-1:0]        pulse_active
);

  // Number of port-index bits. The index slice is kept at least 1 bit wide
  // so that a single-port build still elaborates.
  localparam int          PWS   = $clog2(NPORTS);
  localparam int          IDX_W = (NPORTS > 1) ? PWS : 1;
  localparam logic [31:0] SPAN  = 32'(NPORTS * 32);

  typedef enum logic [2:0] {
    R_DATA = 3'd0,
    R_SET  = 3'd1,
    R_CLR  = 3'd2,
    R_TOG  = 3'd3,
    R_PLEN = 3'd4,
    R_CNT  = 3'd5,
    R_RSV6 = 3'd6,
    R_RSV7 = 3'd7
  } rgn_t;

  // Expand the 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{s[k]}};
    end
    return m;
  endfunction

  // Apply one of the four port-write flavours to the current port value.
  // DATA merges only the enabled bytes. SET, CLR and TOG use the
  // strobe-masked data as their operand.
  function automatic logic [DATA_W-1:0] port_merge(
    input rgn_t              rgn,
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] val,
    input logic [DATA_W-1:0] mask
  );
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] r;
    m = val & mask;
    case (rgn)
      R_DATA:  r = (old_v & ~mask) | m;
      R_SET:   r = old_v | m;
      R_CLR:   r = old_v & ~m;
      R_TOG:   r = old_v ^ m;
      default: r = old_v;
    endcase
    return r;
  endfunction

  // Byte-merge a new pulse length into the stored one.
  function automatic logic [CNT_W-1:0] len_merge(
    input logic [CNT_W-1:0] old_v,
    input logic [CNT_W-1:0] val,
    input logic [CNT_W-1:0] mask
  );
    return (old_v & ~mask) | (val & mask);
  endfunction

  logic [DATA_W-1:0] port_q [NPORTS];
  logic [DATA_W-1:0] port_d [NPORTS];
  logic [CNT_W-1:0]  len_q  [NPORTS];
  logic [CNT_W-1:0]  len_d  [NPORTS];
  logic [CNT_W-1:0]  cnt_q  [NPORTS];
  logic [CNT_W-1:0]  cnt_d  [NPORTS];
  logic [31:0]       rd_data_q;
  logic [31:0]       rd_data_d;
  logic              rd_valid_q;
  logic              rd_valid_d;

  logic [31:0]       off;
  logic [31:0]       word_idx;
  logic              hit;
  logic              wr_hit;
  logic [IDX_W-1:0]  sel_idx;
  rgn_t              sel_rgn;
  logic [31:0]       mask32;
  logic [DATA_W-1:0] dmask;
  logic [DATA_W-1:0] dval;
  logic [CNT_W-1:0]  lmask;
  logic [CNT_W-1:0]  lval;
  logic [31:0]       rd_sel;

  // Address decode. An address below BASE_ADDR wraps to a large offset,
  // so a single unsigned compare also rejects it.
  always_comb begin
    off      = addr - BASE_ADDR;
    hit      = (off < SPAN);
    wr_hit   = write_io_enable && hit;
    word_idx = off >> 2;
    sel_idx  = IDX_W'(word_idx & 32'(NPORTS - 1));
    sel_rgn  = rgn_t'(3'((word_idx >> PWS) & 32'd7));
  end

  // Write operands, narrowed to the port and counter widths.
  always_comb begin
    mask32 = strb_mask(wstrb);
    dmask  = mask32[DATA_W-1:0];
    dval   = datain[DATA_W-1:0];
    lmask  = mask32[CNT_W-1:0];
    lval   = datain[CNT_W-1:0];
  end

  // Next state per port. The countdown and expiry are evaluated first, so a
  // write on the same edge overrides them. A write always uses the
  // pre-edge port value.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      port_d[i] = port_q[i];
      len_d[i]  = len_q[i];
      cnt_d[i]  = cnt_q[i];

      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (cnt_q[i] == CNT_W'(1)) begin
          port_d[i] = '0;
        end
      end

      if (wr_hit && (sel_idx == IDX_W'(i))) begin
        case (sel_rgn)
          R_DATA, R_SET, R_TOG: begin
            port_d[i] = port_merge(sel_rgn, port_q[i], dval, dmask);
            // A zero length reloads zero, which leaves the timer idle.
            cnt_d[i]  = len_q[i];
          end
          R_CLR: begin
            port_d[i] = port_merge(sel_rgn, port_q[i], dval, dmask);
            cnt_d[i]  = '0;
          end
          R_PLEN: begin
            len_d[i] = len_merge(len_q[i], lval, lmask);
            cnt_d[i] = '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Readback mux. It samples pre-edge state, so a read and a write to the
  // same register on one edge returns the old value.
  always_comb begin
    rd_sel = '0;
    if (hit) begin
      case (sel_rgn)
        R_DATA, R_SET, R_CLR, R_TOG: rd_sel = 32'(port_q[sel_idx]);
        R_PLEN:                      rd_sel = 32'(len_q[sel_idx]);
        R_CNT:                       rd_sel = 32'(cnt_q[sel_idx]);
        default:                     rd_sel = '0;
      endcase
    end
    rd_data_d  = read_io_enable ? rd_sel : rd_data_q;
    rd_valid_d = read_io_enable;
  end

  // State registers. Reset is asynchronous, so outputs clear without a clock.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) begin
        port_q[i] <= '0;
        len_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        port_q[i] <= port_d[i];
        len_q[i]  <= len_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  for (genvar g = 0; g < NPORTS; g++) begin : g_out
    assign out_ports[g*DATA_W +: DATA_W] = port_q[g];
    assign pulse_active[g]               = (cnt_q[g] != '0);
  end

endmodule

// File: tb/tb_io_output_bank.sv
// Directed bench for io_output_bank (NPORTS=4, DATA_W=32, CNT_W=16,
// BASE 0x80). Region stride is 0x10: DATA 0x80, SET 0x90, CLR 0xA0,
// TOG 0xB0, PLEN 0xC0, CNT 0xD0, plus 4*port.
// Reads push their expected data into a queue. A monitor pops an entry
// whenever rd_valid is seen and compares it with rd_data.
module tb_io_output_bank;

  logic          io_clk = 1'b0;
  logic          reset  = 1'b0;
  logic [31:0]   addr   = '0;
  logic [31:0]   datain = '0;
  logic [3:0]    wstrb  = '0;
  logic          write_io_enable = 1'b0;
  logic          read_io_enable  = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [127:0]  out_ports;
  logic [3:0]    pulse_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  io_output_bank #(
    .NPORTS(4), .DATA_W(32), .CNT_W(16), .BASE_ADDR(32'h0000_0080)
  ) dut (
    .io_clk(io_clk), .reset(reset), .addr(addr), .datain(datain),
    .wstrb(wstrb), .write_io_enable(write_io_enable),
    .read_io_enable(read_io_enable), .rd_data(rd_data), .rd_valid(rd_valid),
    .out_ports(out_ports), .pulse_active(pulse_active)
  );

  always #5 io_clk = ~io_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] port(input int p);
    return out_ports[p*32 +: 32];
  endfunction

  // All tasks start right after a falling edge and return at the next one.
  task automatic cyc();
    @(negedge io_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; datain = d; wstrb = s; write_io_enable = 1'b1;
    @(negedge io_clk);
    write_io_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name; e.data = exp;
    exp_q.push_back(e);
    addr = a; read_io_enable = 1'b1;
    @(negedge io_clk);
    read_io_enable = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name; e.data = exp;
    exp_q.push_back(e);
    addr = a; datain = d; wstrb = s;
    write_io_enable = 1'b1; read_io_enable = 1'b1;
    @(negedge io_clk);
    write_io_enable = 1'b0; read_io_enable = 1'b0;
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge io_clk);
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got rd_valid=1 data %h expected no read", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e.data) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    reset = 1'b1;
    repeat (3) cyc();
    chk("reset_ports", out_ports, 128'h0);
    chk("reset_pulse_active", 128'(pulse_active), 128'h0);
    chk("reset_rd_valid", 128'(rd_valid), 128'h0);
    reset = 1'b0;
    cyc();

    // 1: full-word write to port0
    wr(32'h80, 32'h1234_5678, 4'b1111);
    chk("t1_full_write", out_ports, 128'h00000000_00000000_00000000_12345678);

    // 2: byte strobes and the SET/CLR/TOG aliases on port1
    wr(32'h84, 32'hFFFF_0000, 4'b1111);
    wr(32'h84, 32'h0000_00AA, 4'b0001);
    chk("t2_byte0", 128'(port(1)), 128'hFFFF_00AA);
    wr(32'h94, 32'h0000_000F, 4'b1111);
    chk("t2_set", 128'(port(1)), 128'hFFFF_00AF);
    wr(32'hA4, 32'hFFFF_0000, 4'b1111);
    chk("t2_clr", 128'(port(1)), 128'h0000_00AF);
    wr(32'hB4, 32'h0000_0001, 4'b1111);
    chk("t2_tog", 128'(port(1)), 128'h0000_00AE);
    wr(32'h84, 32'h1122_3344, 4'b1010);
    chk("t2_strobe_1010", 128'(port(1)), 128'h1100_33AE);
    rd(32'h80, 32'h1234_5678, "t2_rd_port0");
    rd(32'h94, 32'h1100_33AE, "t2_rd_set_alias");
    rd(32'hC4, 32'h0000_0000, "t2_rd_plen1");

    // 3: pulse, len 5
    wr(32'hC8, 32'd5, 4'b1111);
    rd(32'hC8, 32'd5, "t3_rd_plen2");
    wr(32'h88, 32'h0000_00FF, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_hold_c%0d", k), 128'(port(2)), 128'hFF);
      chk($sformatf("t3_active_c%0d", k), 128'(pulse_active), 128'h4);
      cyc();
    end
    chk("t3_expired", 128'(port(2)), 128'h0);
    chk("t3_inactive", 128'(pulse_active), 128'h0);

    // 4: retrigger with len 3
    wr(32'hC8, 32'd3, 4'b1111);
    wr(32'h88, 32'h0000_00AA, 4'b1111);
    cyc();
    wr(32'h88, 32'h0000_000F, 4'b1111);
    chk("t4_retrig_val", 128'(port(2)), 128'h0F);
    rd(32'hD8, 32'd3, "t4_rd_cnt_reload");
    chk("t4_hold_1", 128'(port(2)), 128'h0F);
    cyc();
    chk("t4_hold_2", 128'(port(2)), 128'h0F);
    chk("t4_active_2", 128'(pulse_active), 128'h4);
    cyc();
    chk("t4_expired", 128'(port(2)), 128'h0);

    // 4b: a write on the expiry edge wins and reloads the counter
    wr(32'h88, 32'h0000_0033, 4'b1111);
    cyc();
    cyc();
    wr(32'h88, 32'h0000_0044, 4'b1111);
    chk("t4_collide_val", 128'(port(2)), 128'h44);
    chk("t4_collide_active", 128'(pulse_active), 128'h4);
    rd(32'hD8, 32'd3, "t4_rd_cnt_collide");
    cyc();
    chk("t4_collide_hold", 128'(port(2)), 128'h44);
    cyc();
    chk("t4_collide_expired", 128'(port(2)), 128'h0);

    // 4c: CLR cancels the timer and no auto-clear follows
    wr(32'h88, 32'h0000_0077, 4'b1111);
    wr(32'hA8, 32'h0000_0070, 4'b1111);
    chk("t4_cancel_val", 128'(port(2)), 128'h07);
    chk("t4_cancel_inactive", 128'(pulse_active), 128'h0);
    repeat (4) cyc();
    chk("t4_cancel_no_clear", 128'(port(2)), 128'h07);

    // 5: readback
    wr(32'hC8, 32'd0, 4'b1111);
    rw(32'h88, 32'h0000_0055, 4'b1111, 32'h0000_0007, "t5_rd_pre_write");
    chk("t5_post_write", 128'(port(2)), 128'h55);
    rd(32'h400, 32'h0, "t5_rd_miss");
    rd(32'hE8, 32'h0, "t5_rd_reserved");
    wr(32'h400, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h7C, 32'hDEAD_BEEF, 4'b1111);
    wr(32'hE0, 32'hDEAD_BEEF, 4'b1111);
    wr(32'hD4, 32'hDEAD_BEEF, 4'b1111);
    chk("t5_ignored_writes", out_ports, 128'h00000000_00000055_110033AE_12345678);
    chk("t5_ignored_no_pulse", 128'(pulse_active), 128'h0);
    wr(32'hC8, 32'd4, 4'b1111);
    wr(32'h88, 32'h0000_005A, 4'b1111);
    cyc();
    rd(32'hD8, 32'd3, "t5_rd_live_cnt");

    // 6: asynchronous reset between clock edges while the counter is 2
    chk("t6_pre_reset_active", 128'(pulse_active), 128'h4);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_ports", out_ports, 128'h0);
    chk("t6_async_active", 128'(pulse_active), 128'h0);
    @(negedge io_clk);
    reset = 1'b0;
    repeat (3) cyc();
    chk("t6_post_ports", out_ports, 128'h0);
    chk("t6_post_active", 128'(pulse_active), 128'h0);
    chk("t6_post_rd_valid", 128'(rd_valid), 128'h0);
    rd(32'hC8, 32'h0, "t6_rd_plen_cleared");
    rd(32'hD8, 32'h0, "t6_rd_cnt_cleared");

    cyc();
    chk("rd_queue_drained", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
